// File: rtl/uart_tx_odd_parity_if.sv
// Host-side byte handshake and serial line of the odd-parity UART transmitter.
// The host is the master and the transmitter is the slave.
interface uart_tx_odd_parity_if;
  logic       tx_start;
  logic [7:0] data_in;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_out;

  modport master (
    output tx_start, data_in,
    input  tx_ready, tx_busy, tx_done, tx_out
  );

  modport slave (
    input  tx_start, data_in,
    output tx_ready, tx_busy, tx_done, tx_out
  );
endinterface

// File: rtl/uart_tx_odd_parity.sv
// UART TX, 8 data bits LSB first plus odd parity; the frame starts the cycle after acceptance and lasts 11*CLKS_PER_BIT cycles.
// tx_start is ignored while tx_ready=0; `define UART_TX_HOLD_REG_EN adds a one-byte holding register for gapless frames.
module uart_tx_odd_parity #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_odd_parity_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             par, par_nxt;
  logic             bit_end;
  logic             load;
  logic [7:0]       load_dat;

  logic tx_out_r, tx_ready_r, tx_busy_r, tx_done_r;
  logic tx_out_nxt, tx_ready_nxt, tx_busy_nxt, tx_done_nxt;

`ifdef UART_TX_HOLD_REG_EN
  logic       hold_valid, hold_valid_nxt;
  logic [7:0] hold_dat, hold_dat_nxt;
`endif

  assign bit_end = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    par_nxt   = par;
    load      = 1'b0;
    load_dat  = bus.data_in;
`ifdef UART_TX_HOLD_REG_EN
    hold_valid_nxt = hold_valid;
    hold_dat_nxt   = hold_dat;
`endif

    case (state)
      IDLE: begin
`ifdef UART_TX_HOLD_REG_EN
        if (hold_valid) begin
          load           = 1'b1;
          load_dat       = hold_dat;
          hold_valid_nxt = 1'b0;
        end else if (bus.tx_start) begin
          load = 1'b1;
        end
`else
        if (bus.tx_start) begin
          load = 1'b1;
        end
`endif
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          bit_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          shreg_nxt = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = PARITY;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
`ifdef UART_TX_HOLD_REG_EN
          if (hold_valid) begin
            load           = 1'b1;
            load_dat       = hold_dat;
            hold_valid_nxt = 1'b0;
          end
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

`ifdef UART_TX_HOLD_REG_EN
    // An empty hold register accepts a byte whenever a frame is already running.
    if (bus.tx_start && !hold_valid && (state != IDLE)) begin
      hold_valid_nxt = 1'b1;
      hold_dat_nxt   = bus.data_in;
    end
`endif

    if (load) begin
      state_nxt = START;
      cnt_nxt   = '0;
      bit_nxt   = '0;
      shreg_nxt = load_dat;
      par_nxt   = ~^load_dat;
    end

    // Outputs are derived from the next state so they can be registered without lag.
    case (state_nxt)
      START:   tx_out_nxt = 1'b0;
      DATA:    tx_out_nxt = shreg_nxt[0];
      PARITY:  tx_out_nxt = par_nxt;
      default: tx_out_nxt = 1'b1;
    endcase
    tx_busy_nxt = (state_nxt != IDLE);
    tx_done_nxt = (state_nxt == STOP) && (cnt_nxt == LAST);
`ifdef UART_TX_HOLD_REG_EN
    tx_ready_nxt = ~hold_valid_nxt;
`else
    tx_ready_nxt = (state_nxt == IDLE);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tx_out_r   <= 1'b1;
      tx_ready_r <= 1'b1;
      tx_busy_r  <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_nxt;
      shreg      <= shreg_nxt;
      par        <= par_nxt;
      tx_out_r   <= tx_out_nxt;
      tx_ready_r <= tx_ready_nxt;
      tx_busy_r  <= tx_busy_nxt;
      tx_done_r  <= tx_done_nxt;
    end
  end

`ifdef UART_TX_HOLD_REG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_dat   <= '0;
    end else begin
      hold_valid <= hold_valid_nxt;
      hold_dat   <= hold_dat_nxt;
    end
  end
`endif

  assign bus.tx_out   = tx_out_r;
  assign bus.tx_ready = tx_ready_r;
  assign bus.tx_busy  = tx_busy_r;
  assign bus.tx_done  = tx_done_r;

endmodule
